op_queue_n: RTL and testbench

OP_QUEUE_N -- requirements
Module: op_queue_n

---
 rtl/opq_pkg.sv | 43 ++++
 rtl/op_queue_n_if.sv | 28 ++
 rtl/opq_ring_ram.sv | 35 +++
 rtl/op_queue_n.sv | 108 ++++++++++
 tb/tb_op_queue_n.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/opq_pkg.sv
`default_nettype none
// ============================================================================
// opq_pkg : shared defaults, lane count and packed-op field layout for op_queue_n
// Rev 1.0
// ============================================================================
package opq_pkg;

   localparam int DEF_DEPTH  = 16;
   localparam int DEF_DATA_W = 88;
   localparam int LANES      = 2;

   localparam int OP_W    = 7;
   localparam int RD_W    = 5;
   localparam int RS_W    = 5;
   localparam int IMM_W   = 32;
   localparam int FLAGS_W = 2;
   localparam int ADDR_W  = 32;

   localparam int ADDR_LSB  = 0;
   localparam int FLAGS_LSB = ADDR_LSB + ADDR_W;
   localparam int IMM_LSB   = FLAGS_LSB + FLAGS_W;
   localparam int RS2_LSB   = IMM_LSB + IMM_W;
   localparam int RS1_LSB   = RS2_LSB + RS_W;
   localparam int RD_LSB    = RS1_LSB + RS_W;
   localparam int OP_LSB    = RD_LSB + RD_W;

   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic [RD_W-1:0]    rd;
      logic [RS_W-1:0]    rs1;
      logic [RS_W-1:0]    rs2;
      logic [IMM_W-1:0]   imm;
      logic [FLAGS_W-1:0] flags;
      logic [ADDR_W-1:0]  addr;
   } op_t;

   // Lanes only count when contiguous from lane 0.
   function automatic logic [1:0] lane_count(input logic [1:0] hit);
      return hit[0] ? (hit[1] ? 2'd2 : 2'd1) : 2'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/op_queue_n_if.sv
`default_nettype none
// ============================================================================
// op_queue_n_if : two-lane push/pop handshake bundle for op_queue_n
// Rev 1.0
// ============================================================================
interface op_queue_n_if
   import opq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   logic [1:0]          push_valid_in;
   logic [2*DATA_W-1:0] push_data_in;
   logic [1:0]          push_ready_out;
   logic [1:0]          pop_valid_out;
   logic [2*DATA_W-1:0] pop_data_out;
   logic [1:0]          pop_ack_in;

   modport master (
      output push_valid_in, push_data_in, pop_ack_in,
      input  push_ready_out, pop_valid_out, pop_data_out
   );

   modport slave (
      input  push_valid_in, push_data_in, pop_ack_in,
      output push_ready_out, pop_valid_out, pop_data_out
   );
endinterface
`default_nettype wire

// File: rtl/opq_ring_ram.sv
`default_nettype none
// ============================================================================
// opq_ring_ram : DEPTH x DATA_W storage, two write ports, two async read ports
// Rev 1.0
// ============================================================================
module opq_ring_ram
   import opq_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DATA_W = DEF_DATA_W
)(
   input  wire logic                     clk,
   input  wire logic                     we0,
   input  wire logic [$clog2(DEPTH)-1:0] waddr0,
   input  wire logic [DATA_W-1:0]        wdata0,
   input  wire logic                     we1,
   input  wire logic [$clog2(DEPTH)-1:0] waddr1,
   input  wire logic [DATA_W-1:0]        wdata1,
   input  wire logic [$clog2(DEPTH)-1:0] raddr0,
   output logic      [DATA_W-1:0]        rdata0,
   input  wire logic [$clog2(DEPTH)-1:0] raddr1,
   output logic      [DATA_W-1:0]        rdata1
);
   logic [DATA_W-1:0] mem [DEPTH];

   // Callers never aim both ports at the same slot in one cycle.
   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];
endmodule
`default_nettype wire

// File: rtl/op_queue_n.sv
`default_nettype none
// ============================================================================
// op_queue_n : two-lane in-order op queue with flush and global ready stall
// Optional macro OPQ_BYPASS_EN: empty-queue push-to-pop combinational bypass
// Rev 1.0
// ============================================================================
module op_queue_n
   import opq_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int AF_THRESH = DEPTH - 2
)(
   input  wire logic                       clk_in,
   input  wire logic                       rst_n_in,
   input  wire logic                       rdy_in,
   input  wire logic                       flush_in,
   op_queue_n_if.slave                     io,
   output logic      [$clog2(DEPTH+1)-1:0] count_out,
   output logic                            almost_full_out
);
   localparam int            AW     = $clog2(DEPTH);
   localparam int            CW     = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);

   logic [AW-1:0]       head, tail;
   logic [CW-1:0]       count;
   logic                live;
   logic [1:0]          push_ready, ram_valid, pop_valid;
   logic [1:0]          npush, npop, skip;
   logic [2*DATA_W-1:0] ram_rdata, pop_raw;
   logic                we0, we1;
   logic [DATA_W-1:0]   wdata0, wdata1;

   assign live = rdy_in & rst_n_in;

   // Ready uses registered occupancy only; a same-cycle pop gives no credit.
   assign push_ready = live ? {count < (FULL_C - CW'(1)), count != FULL_C} : 2'b00;
   assign ram_valid  = live ? {count > CW'(1), count != '0} : 2'b00;

   assign npush = lane_count(io.push_valid_in & push_ready);
   assign npop  = lane_count(io.pop_ack_in & pop_valid);

`ifdef OPQ_BYPASS_EN
   logic bypass;
   assign bypass    = live & ~flush_in & (count == '0);
   assign pop_valid = bypass ? {io.push_valid_in[1] & io.push_valid_in[0], io.push_valid_in[0]}
                             : ram_valid;
   assign pop_raw   = bypass ? io.push_data_in : ram_rdata;
   // Acked bypass lanes never touch storage; remaining pushed lanes shift down.
   assign skip      = bypass ? npop : 2'd0;
`else
   assign pop_valid = ram_valid;
   assign pop_raw   = ram_rdata;
   assign skip      = 2'd0;
`endif

   assign we0    = live & ~flush_in & (npush > skip);
   assign we1    = live & ~flush_in & (npush == 2'd2) & (skip == 2'd0);
   assign wdata0 = skip[0] ? io.push_data_in[2*DATA_W-1:DATA_W] : io.push_data_in[DATA_W-1:0];
   assign wdata1 = io.push_data_in[2*DATA_W-1:DATA_W];

   opq_ring_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk    (clk_in),
      .we0    (we0),
      .waddr0 (tail),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (tail + AW'(1)),
      .wdata1 (wdata1),
      .raddr0 (head),
      .rdata0 (ram_rdata[DATA_W-1:0]),
      .raddr1 (head + AW'(1)),
      .rdata1 (ram_rdata[2*DATA_W-1:DATA_W])
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            tail  <= tail + AW'(npush - skip);
            head  <= head + AW'(npop - skip);
            count <= count + CW'(npush) - CW'(npop);
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign io.pop_data_out[k*DATA_W +: DATA_W] = pop_valid[k] ? pop_raw[k*DATA_W +: DATA_W] : '0;
   end

   assign io.push_ready_out = push_ready;
   assign io.pop_valid_out  = pop_valid;
   assign count_out         = count;
   assign almost_full_out   = rst_n_in & (count >= AF_C);
endmodule
`default_nettype wire

// File: tb/tb_op_queue_n.sv
`default_nettype none
// ============================================================================
// tb_op_queue_n : directed self-checking bench for op_queue_n (default build)
// Rev 1.0
// ============================================================================
module tb_op_queue_n;
   localparam int DW = 88;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rdy;
   logic       flush;
   logic [4:0] count;
   logic       af;
   int         checks   = 0;
   int         failures = 0;

   op_queue_n_if #(.DATA_W(DW)) bus ();

   op_queue_n #(
      .DEPTH     (16),
      .DATA_W    (DW),
      .AF_THRESH (14)
   ) dut (
      .clk_in          (clk),
      .rst_n_in        (rst_n),
      .rdy_in          (rdy),
      .flush_in        (flush),
      .io              (bus),
      .count_out       (count),
      .almost_full_out (af)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input int i);
      return {8'(i), 48'hC0DE_0000_BEEF, 32'(i) * 32'd7 + 32'd1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.push_valid_in = 2'b00;
      bus.push_data_in  = '0;
      bus.pop_ack_in    = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; idle();
      #2;
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (bus.push_ready_out !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", bus.push_ready_out); end
      checks++; if (bus.pop_valid_out !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", bus.pop_valid_out); end
      checks++; if (bus.pop_data_out !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.pop_data_out); end
      checks++; if (af !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", af); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.push_valid_in = 2'b01; bus.push_data_in = {mk(0), mk(1)};
      #1;
      checks++; if (bus.push_ready_out !== 2'b11) begin failures++; $display("FAIL post_reset_ready got=%b exp=11", bus.push_ready_out); end
      tick(); idle(); #1;
      checks++; if (count !== 5'd1 || bus.pop_valid_out !== 2'b01 || bus.pop_data_out !== {{DW{1'b0}}, mk(1)})
         begin failures++; $display("FAIL first_push got cnt=%0d v=%b d=%h exp cnt=1 v=01", count, bus.pop_valid_out, bus.pop_data_out); end
      bus.pop_ack_in = 2'b01;
      tick(); idle(); #1;
   endtask

   task automatic test_push_two();
      bus.push_valid_in = 2'b11; bus.push_data_in = {mk(11), mk(10)};
      #1;
`ifndef OPQ_BYPASS_EN
      checks++; if (bus.pop_valid_out !== 2'b00) begin failures++; $display("FAIL no_same_cycle got=%b exp=00", bus.pop_valid_out); end
`endif
      tick(); idle(); #1;
      checks++; if (bus.pop_valid_out !== 2'b11) begin failures++; $display("FAIL push2_valid got=%b exp=11", bus.pop_valid_out); end
      checks++; if (bus.pop_data_out !== {mk(11), mk(10)}) begin failures++; $display("FAIL push2_data got=%h exp=%h", bus.pop_data_out, {mk(11), mk(10)}); end
      checks++; if (count !== 5'd2) begin failures++; $display("FAIL push2_count got=%0d exp=2", count); end
      bus.pop_ack_in = 2'b11;
      tick(); idle(); #1;
      checks++; if (count !== 5'd0 || bus.pop_valid_out !== 2'b00 || bus.pop_data_out !== '0)
         begin failures++; $display("FAIL pop2_empty got cnt=%0d v=%b exp cnt=0 v=00", count, bus.pop_valid_out); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         bus.push_valid_in = 2'b11; bus.push_data_in = {mk(100 + 2*i + 1), mk(100 + 2*i)};
         #1;
         checks++; if (count !== 5'(2*i) || af !== (2*i >= 14))
            begin failures++; $display("FAIL fill_step%0d got cnt=%0d af=%b exp cnt=%0d", i, count, af, 2*i); end
         tick();
      end
      idle(); #1;
      checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", count); end
      checks++; if (bus.push_ready_out !== 2'b00) begin failures++; $display("FAIL full_ready got=%b exp=00", bus.push_ready_out); end
      checks++; if (af !== 1'b1) begin failures++; $display("FAIL full_af got=%b exp=1", af); end
      checks++; if (bus.pop_data_out !== {mk(101), mk(100)}) begin failures++; $display("FAIL full_head got=%h exp=%h", bus.pop_data_out, {mk(101), mk(100)}); end
      bus.push_valid_in = 2'b11; bus.push_data_in = {mk(901), mk(900)}; bus.pop_ack_in = 2'b01;
      tick(); idle(); #1;
      checks++; if (count !== 5'd15 || bus.push_ready_out !== 2'b01)
         begin failures++; $display("FAIL one_free got cnt=%0d rdy=%b exp cnt=15 rdy=01", count, bus.push_ready_out); end
      checks++; if (bus.pop_data_out !== {mk(102), mk(101)}) begin failures++; $display("FAIL one_free_data got=%h exp=%h", bus.pop_data_out, {mk(102), mk(101)}); end
      bus.push_valid_in = 2'b11; bus.push_data_in = {mk(117), mk(116)};
      tick(); idle(); #1;
      checks++; if (count !== 5'd16 || bus.push_ready_out !== 2'b00)
         begin failures++; $display("FAIL refill got cnt=%0d rdy=%b exp cnt=16 rdy=00", count, bus.push_ready_out); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (bus.pop_valid_out !== 2'b11 || bus.pop_data_out !== {mk(102 + 2*i), mk(101 + 2*i)})
            begin failures++; $display("FAIL drain%0d got v=%b d=%h exp=%h", i, bus.pop_valid_out, bus.pop_data_out, {mk(102 + 2*i), mk(101 + 2*i)}); end
         bus.pop_ack_in = 2'b11;
         tick();
      end
      idle(); #1;
      checks++; if (count !== 5'd0 || bus.pop_valid_out !== 2'b00) begin failures++; $display("FAIL drained got cnt=%0d v=%b exp cnt=0 v=00", count, bus.pop_valid_out); end
   endtask

   task automatic test_lane_rules();
      bus.push_valid_in = 2'b10; bus.push_data_in = {mk(201), mk(202)};
      tick(); idle(); #1;
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL lane1_only_push got cnt=%0d exp=0", count); end
      bus.push_valid_in = 2'b01; bus.push_data_in = {mk(999), mk(200)};
      tick(); idle(); #1;
      checks++; if (bus.pop_valid_out !== 2'b01 || bus.pop_data_out !== {{DW{1'b0}}, mk(200)})
         begin failures++; $display("FAIL one_entry got v=%b d=%h exp v=01", bus.pop_valid_out, bus.pop_data_out); end
      bus.pop_ack_in = 2'b10;
      tick(); idle(); #1;
      checks++; if (count !== 5'd1) begin failures++; $display("FAIL lane1_only_ack got cnt=%0d exp=1", count); end
      bus.pop_ack_in = 2'b11;
      tick(); idle(); #1;
      checks++; if (count !== 5'd0 || bus.pop_valid_out !== 2'b00) begin failures++; $display("FAIL ack_invalid_lane got cnt=%0d v=%b exp cnt=0 v=00", count, bus.pop_valid_out); end
   endtask

   task automatic test_back_to_back();
      bus.push_valid_in = 2'b11; bus.push_data_in = {mk(301), mk(300)};
      tick();
      for (int c = 0; c < 20; c++) begin
         bus.push_valid_in = 2'b11; bus.push_data_in = {mk(303 + 2*c), mk(302 + 2*c)};
         bus.pop_ack_in = 2'b11;
         #1;
         checks++; if (count !== 5'd2 || bus.pop_valid_out !== 2'b11 || bus.pop_data_out !== {mk(301 + 2*c), mk(300 + 2*c)})
            begin failures++; $display("FAIL b2b%0d got cnt=%0d d=%h exp=%h", c, count, bus.pop_data_out, {mk(301 + 2*c), mk(300 + 2*c)}); end
         tick();
      end
      idle(); bus.pop_ack_in = 2'b11;
      tick(); idle(); #1;
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL b2b_drain got cnt=%0d exp=0", count); end
   endtask

   task automatic test_flush();
      bus.push_valid_in = 2'b11; bus.push_data_in = {mk(401), mk(400)}; tick();
      bus.push_data_in = {mk(403), mk(402)}; tick();
      bus.push_valid_in = 2'b01; bus.push_data_in = {mk(0), mk(404)}; tick();
      idle(); #1;
      checks++; if (count !== 5'd5 || af !== 1'b0) begin failures++; $display("FAIL pre_flush got cnt=%0d af=%b exp cnt=5 af=0", count, af); end
      flush = 1'b1; bus.push_valid_in = 2'b11; bus.push_data_in = {mk(411), mk(410)}; bus.pop_ack_in = 2'b11;
      tick(); flush = 1'b0; idle(); #1;
      checks++; if (count !== 5'd0 || bus.pop_valid_out !== 2'b00 || bus.pop_data_out !== '0)
         begin failures++; $display("FAIL flush got cnt=%0d v=%b exp cnt=0 v=00", count, bus.pop_valid_out); end
      bus.push_valid_in = 2'b01; bus.push_data_in = {mk(0), mk(420)};
      tick(); idle(); #1;
      checks++; if (count !== 5'd1 || bus.pop_data_out !== {{DW{1'b0}}, mk(420)})
         begin failures++; $display("FAIL post_flush got cnt=%0d d=%h exp cnt=1", count, bus.pop_data_out); end
      bus.pop_ack_in = 2'b01; tick(); idle(); #1;
   endtask

   task automatic test_rdy_low();
      bus.push_valid_in = 2'b11; bus.push_data_in = {mk(501), mk(500)}; tick();
      bus.push_valid_in = 2'b01; bus.push_data_in = {mk(0), mk(502)}; tick();
      rdy = 1'b0; flush = 1'b1;
      bus.push_valid_in = 2'b11; bus.push_data_in = {mk(511), mk(510)}; bus.pop_ack_in = 2'b11;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (count !== 5'd3 || bus.push_ready_out !== 2'b00 || bus.pop_valid_out !== 2'b00 || bus.pop_data_out !== '0)
            begin failures++; $display("FAIL stall%0d got cnt=%0d rdy=%b v=%b exp cnt=3 rdy=00 v=00", c, count, bus.push_ready_out, bus.pop_valid_out); end
         tick();
      end
      rdy = 1'b1; flush = 1'b0; idle(); #1;
      checks++; if (bus.pop_valid_out !== 2'b11 || bus.pop_data_out !== {mk(501), mk(500)})
         begin failures++; $display("FAIL unstall got v=%b d=%h exp=%h", bus.pop_valid_out, bus.pop_data_out, {mk(501), mk(500)}); end
      bus.pop_ack_in = 2'b11;
      tick(); idle(); #1;
      checks++; if (count !== 5'd1 || bus.pop_data_out !== {{DW{1'b0}}, mk(502)})
         begin failures++; $display("FAIL unstall_tail got cnt=%0d d=%h exp cnt=1", count, bus.pop_data_out); end
      bus.pop_ack_in = 2'b01; tick(); idle(); #1;
   endtask

   task automatic test_async_reset();
      bus.push_valid_in = 2'b11;
      for (int c = 0; c < 3; c++) begin
         bus.push_data_in = {mk(701 + 2*c), mk(700 + 2*c)};
         tick();
      end
      bus.push_valid_in = 2'b01; bus.push_data_in = {mk(0), mk(706)}; tick();
      idle(); #1;
      checks++; if (count !== 5'd7) begin failures++; $display("FAIL pre_reset got cnt=%0d exp=7", count); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (count !== 5'd0 || bus.pop_valid_out !== 2'b00 || bus.push_ready_out !== 2'b00 || bus.pop_data_out !== '0 || af !== 1'b0)
         begin failures++; $display("FAIL async_reset got cnt=%0d v=%b rdy=%b af=%b exp all zero", count, bus.pop_valid_out, bus.push_ready_out, af); end
      #1 rst_n = 1'b1;
      bus.push_valid_in = 2'b01; bus.push_data_in = {mk(0), mk(800)};
      tick(); idle(); #1;
      checks++; if (count !== 5'd1 || bus.pop_data_out !== {{DW{1'b0}}, mk(800)})
         begin failures++; $display("FAIL after_async got cnt=%0d d=%h exp cnt=1", count, bus.pop_data_out); end
   endtask

   initial begin
      test_reset();
      test_push_two();
      test_fill();
      test_lane_rules();
      test_back_to_back();
      test_flush();
      test_rdy_low();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
